// File: rtl/conv213_pkg.sv
// Shared definitions for the (2,1,3) convolutional encoder: state encoding,
// code constants and the generator function used by encoder and reference models.
package conv213_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL  = 2'd2,
        DRAIN = 2'd3
    } conv213_state_t;

    localparam int          K        = 3;
    localparam int          TAIL_LEN = 2;
    localparam logic [2:0]  G0       = 3'b111;
    localparam logic [2:0]  G1       = 3'b101;

    // Returns {g0,g1} for input bit b and history sr ({bit before previous, previous}).
    function automatic logic [1:0] conv213_encode(input logic b, input logic [1:0] sr);
        logic [2:0] taps;
        taps = {b, sr[0], sr[1]};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

endpackage

// File: rtl/conv_enc_213.sv
// Frame-based rate-1/2 K=3 convolutional encoder (G0=7, G1=5) with two zero tail bits.
// Optional symbol error injection port when CONV_ENC_213_ERRINJ_EN is defined.
module conv_enc_213
    import conv213_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 10
) (
    input  logic       clock,
    input  logic       reset,
`ifdef CONV_ENC_213_ERRINJ_EN
    input  logic       err_inj,
`endif
    input  logic       start,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_sym,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);

    conv213_state_t   state_r, state_nxt_s;
    logic [1:0]       sr_r, sr_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             tail_r, tail_nxt_s;
    logic [1:0]       sym_r;
    logic             valid_r, last_r;
    logic             slot_free_s, load_s, enc_bit_s, load_last_s;
    logic             in_ready_s, frame_done_s, inj_s;

`ifdef CONV_ENC_213_ERRINJ_EN
    assign inj_s = err_inj;
`else
    assign inj_s = 1'b0;
`endif

    assign slot_free_s = !valid_r || out_ready;

    // Next-state, shift-register, counter and symbol-load decisions.
    always_comb begin
        state_nxt_s  = state_r;
        sr_nxt_s     = sr_r;
        cnt_nxt_s    = cnt_r;
        tail_nxt_s   = tail_r;
        load_s       = 1'b0;
        enc_bit_s    = 1'b0;
        load_last_s  = 1'b0;
        in_ready_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sr_nxt_s    = 2'b00;
                    cnt_nxt_s   = '0;
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DATA: begin
                in_ready_s = slot_free_s;
                if (in_valid && slot_free_s) begin
                    load_s    = 1'b1;
                    enc_bit_s = in_bit;
                    sr_nxt_s  = {sr_r[0], in_bit};
                    if (cnt_r == CNT_W'(FRAME_LEN - 1)) begin
                        tail_nxt_s  = 1'b0;
                        state_nxt_s = TAIL;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            TAIL: begin
                if (slot_free_s) begin
                    load_s   = 1'b1;
                    sr_nxt_s = {sr_r[0], 1'b0};
                    if (tail_r) begin
                        load_last_s = 1'b1;
                        state_nxt_s = DRAIN;
                    end else begin
                        tail_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = TAIL;
                end
            end
            DRAIN: begin
                if (valid_r && out_ready) begin
                    frame_done_s = 1'b1;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state, encoder history and frame counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            sr_r    <= 2'b00;
            cnt_r   <= '0;
            tail_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sr_r    <= sr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            tail_r  <= tail_nxt_s;
        end
    end

    // Output symbol register; holds its contents while downstream stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            sym_r   <= 2'b00;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load_s) begin
            sym_r   <= conv213_encode(enc_bit_s, sr_r) ^ {inj_s, inj_s};
            valid_r <= 1'b1;
            last_r  <= load_last_s;
        end else if (out_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= valid_r;
            last_r  <= last_r;
        end
    end

    assign out_sym    = sym_r;
    assign out_valid  = valid_r;
    assign out_last   = last_r;
    assign in_ready   = in_ready_s;
    assign frame_done = frame_done_s;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_conv_enc_213.sv
// Directed self-checking bench for conv_enc_213 with FRAME_LEN=4.
// Error-injection scenario is built only when CONV_ENC_213_ERRINJ_EN is defined.
module tb_conv_enc_213;

    localparam int FL = 4;

    logic       clock = 1'b0;
    logic       reset, start, in_bit, in_valid, out_ready, err_inj;
    logic       in_ready, out_valid, out_last, busy, frame_done;
    logic [1:0] out_sym;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] got_sym  [8];
    logic       got_last [8];
    logic       got_fd   [8];
    int         n_got, stall_viol, rdy_viol, extra_fd;
    bit         timed_out;

    always #5 clock = ~clock;

    conv_enc_213 #(.FRAME_LEN(FL), .CNT_W(10)) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef CONV_ENC_213_ERRINJ_EN
        .err_inj    (err_inj),
`endif
        .start      (start),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sym    (out_sym),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Streams bits[0..FL-1] and records every accepted symbol until the last one.
    task automatic collect(input logic [3:0] bits, input bit tog, input bit hold_start, input int inj_idx);
        int  bi, cyc;
        bit  done, prev_stall;
        logic [1:0] prev_sym;
        logic prev_last;
        n_got = 0; stall_viol = 0; rdy_viol = 0; extra_fd = 0; timed_out = 1'b0;
        bi = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0; prev_sym = 2'b00; prev_last = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clock);
            start     = hold_start;
            out_ready = tog ? ((cyc % 2) == 1) : 1'b1;
            in_valid  = 1'b1;
            in_bit    = (bi < FL) ? bits[bi] : 1'b1;
            err_inj   = (bi == inj_idx) && (bi < FL);
            #1;
            if (prev_stall && (out_sym !== prev_sym || out_last !== prev_last)) stall_viol++;
            if (bi >= FL && in_ready) rdy_viol++;
            if (out_valid && out_ready) begin
                if (n_got < 8) begin
                    got_sym[n_got]  = out_sym;
                    got_last[n_got] = out_last;
                    got_fd[n_got]   = frame_done;
                end
                n_got++;
                if (out_last) done = 1'b1;
            end else if (frame_done) begin
                extra_fd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sym   = out_sym;
            prev_last  = out_last;
            if (in_valid && in_ready) bi++;
            cyc++;
        end
        if (!done) timed_out = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        err_inj  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_inj = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_sym !== 2'b00)   begin n_fail++; $display("FAIL reset_out_sym got=%b exp=00", out_sym); end
        n_checks++; if (out_last !== 1'b0)   begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        reset = 1'b0;
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_bit = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid cyc=%0d got=%b exp=0", i, out_valid); end
        end
        in_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic(input bit tog, input bit hold_start);
        logic [11:0] exp;
        exp = 12'b11_10_00_01_01_11;
        do_start();
        collect(4'b1101, tog, hold_start, -1);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout tog=%0d got=%b exp=0", tog, timed_out); end
        n_checks++; if (n_got !== 6) begin n_fail++; $display("FAIL basic_count tog=%0d got=%0d exp=6", tog, n_got); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_sym[i] !== exp[11-2*i -: 2] || got_last[i] !== (i == 5) || got_fd[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL basic_sym tog=%0d hs=%0d idx=%0d got=%b/%b/%b exp=%b/%b/%b", tog, hold_start, i,
                         got_sym[i], got_last[i], got_fd[i], exp[11-2*i -: 2], (i == 5), (i == 5));
            end
        end
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL basic_stall_stable got=%0d exp=0", stall_viol); end
        n_checks++; if (rdy_viol !== 0)   begin n_fail++; $display("FAIL basic_tail_in_ready got=%0d exp=0", rdy_viol); end
        n_checks++; if (extra_fd !== 0)   begin n_fail++; $display("FAIL basic_extra_done got=%0d exp=0", extra_fd); end
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_start();
        collect(4'b1101, 1'b0, 1'b0, -1);
        do_start();
        collect(4'b0000, 1'b0, 1'b0, -1);
        n_checks++; if (n_got !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", n_got); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_sym[i] !== 2'b00 || got_last[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL b2b_sym idx=%0d got=%b/%b exp=00/%b", i, got_sym[i], got_last[i], (i == 5));
            end
        end
    endtask

    task automatic test_reset_mid_tail();
        logic [3:0]  bits;
        logic [11:0] exp;
        bits = 4'b1101;
        exp  = 12'b11_10_00_01_01_11;
        do_start();
        for (int i = 0; i < FL; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_bit = bits[i]; out_ready = 1'b1;
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL tail_state busy=%b in_ready=%b exp=1/0", busy, in_ready); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tail_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_tail_busy got=%b exp=0", busy); end
        n_checks++; if (out_last !== 1'b0)  begin n_fail++; $display("FAIL rst_tail_last got=%b exp=0", out_last); end
        do_start();
        collect(bits, 1'b0, 1'b0, -1);
        n_checks++; if (n_got !== 6) begin n_fail++; $display("FAIL rst_refr_count got=%0d exp=6", n_got); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_sym[i] !== exp[11-2*i -: 2]) begin
                n_fail++;
                $display("FAIL rst_refr_sym idx=%0d got=%b exp=%b", i, got_sym[i], exp[11-2*i -: 2]);
            end
        end
    endtask

`ifdef CONV_ENC_213_ERRINJ_EN
    task automatic test_err_inj();
        logic [11:0] exp;
        exp = 12'b11_01_00_01_01_11;
        do_start();
        collect(4'b1101, 1'b0, 1'b0, 1);
        n_checks++; if (n_got !== 6) begin n_fail++; $display("FAIL errinj_count got=%0d exp=6", n_got); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_sym[i] !== exp[11-2*i -: 2]) begin
                n_fail++;
                $display("FAIL errinj_sym idx=%0d got=%b exp=%b", i, got_sym[i], exp[11-2*i -: 2]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic(1'b0, 1'b0);
        test_basic(1'b1, 1'b0);
        test_basic(1'b0, 1'b1);
        test_back_to_back();
        test_reset_mid_tail();
`ifdef CONV_ENC_213_ERRINJ_EN
        test_err_inj();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
